// File: rtl/reg3_write_arbiter.sv
// Round-robin write arbiter/sequencer for a shared WIDTH-bit register (IDLE -> GRANT -> WRITE).
// Optional build macro REG3ARB_FIXED_PRIO_EN selects fixed priority req[0] > req[1] > req[2].
module reg3_write_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [2:0]       gnt,
    output logic [2:0]       ack,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic [1:0]       last_owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [1:0]       r_winner, w_winner_next;
    logic [2:0]       r_gnt, w_gnt_next;
    logic [2:0]       r_ack, w_ack_next;
    logic [WIDTH-1:0] r_q, w_q_next;
    logic [1:0]       r_last_owner, w_last_owner_next;
    logic [1:0]       w_start;
    logic [1:0]       w_pick;
    logic [1:0]       w_rot_idx [3];
    logic [WIDTH-1:0] w_win_data;

`ifdef REG3ARB_FIXED_PRIO_EN
    assign w_start = 2'd0;
`else
    assign w_start = (r_last_owner == 2'd2) ? 2'd0 : r_last_owner + 2'd1;
`endif

    // w_rot_idx[k] is the requester holding the k-th highest priority this round.
    for (genvar gi = 0; gi < 3; gi++) begin : g_rot
        logic [2:0] w_sum;
        assign w_sum          = {1'b0, w_start} + 3'(gi);
        assign w_rot_idx[gi]  = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
    end

    always_comb begin
        w_pick = w_start;
        for (int k = 2; k >= 0; k--) begin
            if (req[w_rot_idx[k]]) begin
                w_pick = w_rot_idx[k];
            end
        end
    end

    always_comb begin
        case (r_winner)
            2'd1:    w_win_data = data1;
            2'd2:    w_win_data = data2;
            default: w_win_data = data0;
        endcase
    end

    always_comb begin
        w_state_next      = r_state;
        w_winner_next     = r_winner;
        w_gnt_next        = 3'b000;
        w_ack_next        = 3'b000;
        w_q_next          = r_q;
        w_last_owner_next = r_last_owner;
        case (r_state)
            IDLE: begin
                if (req != 3'b000) begin
                    w_winner_next = w_pick;
                    w_gnt_next    = 3'b001 << w_pick;
                    w_state_next  = GRANT;
                end
            end
            GRANT: begin
                // A winner that withdrew its request aborts without touching q or the pointer.
                if (req[r_winner]) begin
                    w_q_next     = w_win_data;
                    w_ack_next   = 3'b001 << r_winner;
                    w_state_next = WRITE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            WRITE: begin
                w_last_owner_next = r_winner;
                w_state_next      = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_winner     <= 2'd0;
            r_gnt        <= 3'b000;
            r_ack        <= 3'b000;
            r_q          <= '0;
            r_last_owner <= 2'd2;
        end else begin
            r_state      <= w_state_next;
            r_winner     <= w_winner_next;
            r_gnt        <= w_gnt_next;
            r_ack        <= w_ack_next;
            r_q          <= w_q_next;
            r_last_owner <= w_last_owner_next;
        end
    end

    assign gnt        = r_gnt;
    assign ack        = r_ack;
    assign q          = r_q;
    assign busy       = (r_state != IDLE);
    assign last_owner = r_last_owner;

endmodule

// File: doc/reg3_write_arbiter.md
# reg3_write_arbiter

Round-robin write arbiter and sequencer for a shared 3-bit register.
- Three requesters each present a 3-bit value and a request; the block grants one at a time and performs the write.
- Each completed write is acknowledged with a single-cycle pulse to the winner.
- Sits in front of the shared state register, replacing direct D-input drive by multiple sources.

## Interface
Parameters:
- WIDTH, 3, data width of the shared register and of each requester's data input.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- req  input  3  request lines; req[i] belongs to requester i.
- data0  input  WIDTH  value requester 0 wants written.
- data1  input  WIDTH  value requester 1 wants written.
- data2  input  WIDTH  value requester 2 wants written.
- gnt  output  3  one-hot grant, all zero when no grant active.
- ack  output  3  one-hot single-cycle write-complete pulse.
- q  output  WIDTH  shared register contents.
- busy  output  1  high whenever state is not IDLE.
- last_owner  output  2  index (0..2) of the last requester whose write completed.

## Operation
- FSM states: IDLE, GRANT, WRITE (registered).
- IDLE:
  - If req is nonzero, select a winner using priority order starting at last_owner+1 mod 3, then go to GRANT with gnt[winner]=1.
  - If req is zero, stay in IDLE.
- GRANT:
  - If req[winner] is still 1, load q with the winner's data, go to WRITE, drop gnt and assert ack[winner].
  - If req[winner] has dropped, abort: go to IDLE, gnt=0, no write, no ack, last_owner unchanged.
- WRITE:
  - Set last_owner=winner.
  - Return to IDLE unconditionally; ack cleared on that edge.
- Requesters must deassert req in the cycle ack is seen. A req still high in IDLE is treated as a new request.
- The winner's data is sampled only in the GRANT cycle; data on non-granted inputs is ignored.
- The winner index is held internally from IDLE through WRITE.
- q changes only on completed writes and reset.

## Timing
- Reset values: state=IDLE, gnt=3'b000, ack=3'b000, q=0, busy=0, last_owner=2 (so requester 0 has first priority).
- Latency: req sampled high at edge E0 gives:
  - gnt valid after E0;
  - q updated and ack asserted after E1;
  - back in IDLE after E2.
- Throughput: at most one write per 3 cycles.
- gnt and ack are never high in the same cycle. Each is zero-or-one-hot.
- Simultaneous requests are resolved by the rotating priority only. A continuously requesting set is served in cyclic order, with no starvation.
- Reset asserted in any state overrides everything at that edge: no write, no ack, all outputs take reset values next cycle.
- An abort in GRANT leaves q, last_owner and the priority pointer unchanged.

## Configuration
- REG3ARB_FIXED_PRIO_EN defined:
  - Fixed priority req[0] > req[1] > req[2], ignoring last_owner.
  - last_owner is still updated and output.
- Undefined (default): round-robin as described above.

## Test plan
- Reset then idle: hold reset 2 cycles, release with req=0 for 5 cycles -> q=0, gnt=0, ack=0, busy=0, last_owner=2 throughout.
- Single write: req=3'b010, data1=3'b101 -> gnt=3'b010 one cycle later. Next cycle q=3'b101 and ack=3'b010 for exactly one cycle, last_owner=1. Bench drops req on ack.
- Round-robin contention: req=3'b111 held, data0=1, data1=2, data2=3:
  - Default build: acks in order 0,1,2,0, with q=1,2,3,1.
  - With REG3ARB_FIXED_PRIO_EN: all acks go to 0, q=1.
- Abort: req=3'b100, then drop req[2] during the GRANT cycle -> no ack, q unchanged, FSM back in IDLE, last_owner unchanged.
- Reset mid-operation: assert reset during the GRANT cycle of a write of 3'b111 -> q stays 0, gnt=0, ack never pulses, busy=0 next cycle.
